// File: rtl/mmio_register_bank_pkg.sv
// Shared widths, request-size and response-code encodings for the MMIO register bank.
// Pure definitions: no latency, no flow control.
package mmio_register_bank_pkg;

  localparam int ADDR_W      = 32;
  localparam int WORD_W      = 32;
  localparam int WORD_BYTES  = WORD_W / 8;
  localparam int MEM_COUNT_W = 2;
  localparam int MEM_CODE_W  = 3;

  typedef enum logic [MEM_COUNT_W-1:0] {
    MEM_COUNT_NONE = 2'd0,
    MEM_COUNT_BYTE = 2'd1,
    MEM_COUNT_HALF = 2'd2,
    MEM_COUNT_WORD = 2'd3
  } mem_count_t;

  typedef enum logic [MEM_CODE_W-1:0] {
    MEM_CODE_INVALID      = 3'd0,
    MEM_CODE_READ         = 3'd1,
    MEM_CODE_WRITE        = 3'd2,
    MEM_CODE_MISALIGNED   = 3'd3,
    MEM_CODE_OUT_OF_RANGE = 3'd4
  } mem_code_t;

  function automatic logic [WORD_W-1:0] byte_mask(input logic [WORD_BYTES-1:0] be);
    logic [WORD_W-1:0] m;
    m = '0;
    for (int b = 0; b < WORD_BYTES; b++) m[b*8 +: 8] = {8{be[b]}};
    return m;
  endfunction

endpackage

// File: rtl/mmio_register_bank_if.sv
// Request/response bus between a data-memory master and the register bank.
// Response follows each request by one clock; no stall or backpressure signals exist.
interface mmio_register_bank_if
  import mmio_register_bank_pkg::*;
();
  logic [ADDR_W-1:0] req_addr;
  mem_count_t        req_count;
  logic              req_wr_en;
  logic [WORD_W-1:0] req_wr_data;
  logic [WORD_W-1:0] res_rd_data;
  mem_code_t         res_code;

  modport master (output req_addr, req_count, req_wr_en, req_wr_data,
                  input  res_rd_data, res_code);
  modport slave  (input  req_addr, req_count, req_wr_en, req_wr_data,
                  output res_rd_data, res_code);
endinterface

// File: rtl/mmio_register_bank_lane_ctrl.sv
// Combinational byte-lane steering: byte enables, alignment check, write replication, read extraction.
// Zero latency, no backpressure.
module mem_lane_ctrl
  import mmio_register_bank_pkg::*;
(
  input  mem_count_t            i_count,
  input  logic [1:0]            i_lane,
  input  logic [WORD_W-1:0]     i_wr_data,
  input  logic [WORD_W-1:0]     i_rd_word,
  output logic [WORD_BYTES-1:0] o_byte_en,
  output logic                  o_misaligned,
  output logic [WORD_W-1:0]     o_wr_data,
  output logic [WORD_W-1:0]     o_rd_data
);
  logic [WORD_W-1:0] w_rd_shift;

  assign w_rd_shift = i_rd_word >> {i_lane, 3'b000};

  // Sub-word store data is replicated so every lane carries (k mod size) source byte.
  always_comb begin
    o_byte_en    = '0;
    o_misaligned = 1'b0;
    o_wr_data    = '0;
    o_rd_data    = '0;
    case (i_count)
      MEM_COUNT_BYTE: begin
        o_byte_en = WORD_BYTES'(1) << i_lane;
        o_wr_data = {WORD_BYTES{i_wr_data[7:0]}};
        o_rd_data = {{(WORD_W-8){1'b0}}, w_rd_shift[7:0]};
      end
      MEM_COUNT_HALF: begin
        o_misaligned = i_lane[0];
        o_byte_en    = WORD_BYTES'(3) << i_lane;
        o_wr_data    = {(WORD_BYTES/2){i_wr_data[15:0]}};
        o_rd_data    = {{(WORD_W-16){1'b0}}, w_rd_shift[15:0]};
      end
      MEM_COUNT_WORD: begin
        o_misaligned = |i_lane;
        o_byte_en    = '1;
        o_wr_data    = i_wr_data;
        o_rd_data    = i_rd_word;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mmio_register_bank.sv
// CSR bank of RW, sticky W1C and read-only live bits behind the data-memory bus.
// One-cycle registered response, one request per cycle, never stalls.
module mmio_register_bank
  import mmio_register_bank_pkg::*;
#(
  parameter int                          WORD_COUNT  = 4,
  parameter logic [ADDR_W-1:0]           ADDR_START  = '0,
  parameter logic [WORD_COUNT*WORD_W-1:0] RW_MASK     = '0,
  parameter logic [WORD_COUNT*WORD_W-1:0] W1C_MASK    = '0,
  parameter logic [WORD_COUNT*WORD_W-1:0] RESET_VALUE = '0
) (
  input  logic                         clk,
  input  logic                         aresetn,
  mmio_register_bank_if.slave          bus,
  input  logic [WORD_COUNT*WORD_W-1:0] i_hw_status,
  input  logic [WORD_COUNT*WORD_W-1:0] i_hw_event,
  output logic [WORD_COUNT*WORD_W-1:0] o_regs,
  output logic [WORD_COUNT-1:0]        o_wr_strobe,
  output logic                         o_irq
);
  localparam int IDX_W  = (WORD_COUNT > 1) ? $clog2(WORD_COUNT) : 1;
  localparam int BANK_W = WORD_COUNT * WORD_W;
  localparam logic [BANK_W-1:0] RO_MASK = ~(RW_MASK | W1C_MASK);

  logic [BANK_W-1:0]     r_rw, r_sticky, w_rw_nxt, w_sticky_nxt, w_bank_rd;
  logic [WORD_COUNT-1:0] r_wr_strobe, w_wr_sel;
  logic                  r_irq;
  logic [WORD_W-1:0]     r_rd_data, w_rd_word, w_lane_wr, w_lane_rd, w_lane_mask;
  mem_code_t             r_code, w_code;
  logic [ADDR_W-1:0]     w_off;
  logic [IDX_W-1:0]      w_idx;
  logic                  w_in_range, w_misaligned, w_wr_ok;
  logic [WORD_BYTES-1:0] w_byte_en;

  assign w_off      = bus.req_addr - ADDR_START;
  assign w_idx      = w_off[IDX_W+1:2];
  assign w_in_range = (bus.req_addr >= ADDR_START) &&
                      (w_off[ADDR_W-1:2] < (ADDR_W-2)'(WORD_COUNT));
  assign w_bank_rd  = (r_rw & RW_MASK) | (r_sticky & W1C_MASK) | (i_hw_status & RO_MASK);
  assign w_rd_word  = w_bank_rd[w_idx*WORD_W +: WORD_W];

  mem_lane_ctrl u_lane_ctrl (
    .i_count      (bus.req_count),
    .i_lane       (w_off[1:0]),
    .i_wr_data    (bus.req_wr_data),
    .i_rd_word    (w_rd_word),
    .o_byte_en    (w_byte_en),
    .o_misaligned (w_misaligned),
    .o_wr_data    (w_lane_wr),
    .o_rd_data    (w_lane_rd)
  );

  assign w_lane_mask = byte_mask(w_byte_en);

  always_comb begin
    w_code = MEM_CODE_READ;
    if (bus.req_count == MEM_COUNT_NONE) w_code = MEM_CODE_INVALID;
    else if (w_misaligned)               w_code = MEM_CODE_MISALIGNED;
    else if (!w_in_range)                w_code = MEM_CODE_OUT_OF_RANGE;
    else if (bus.req_wr_en)              w_code = MEM_CODE_WRITE;
  end

  assign w_wr_ok = (w_code == MEM_CODE_WRITE);

  // Events are OR-ed in after the W1C clear so a same-cycle set wins.
  always_comb begin
    w_wr_sel     = '0;
    w_rw_nxt     = r_rw;
    w_sticky_nxt = r_sticky;
    for (int i = 0; i < WORD_COUNT; i++) begin
      w_wr_sel[i] = w_wr_ok && (w_idx == IDX_W'(i));
      if (w_wr_sel[i]) begin
        w_rw_nxt[i*WORD_W +: WORD_W]     = (r_rw[i*WORD_W +: WORD_W] & ~w_lane_mask) |
                                           (w_lane_wr & w_lane_mask);
        w_sticky_nxt[i*WORD_W +: WORD_W] = r_sticky[i*WORD_W +: WORD_W] &
                                           ~(w_lane_wr & w_lane_mask);
      end
    end
    w_rw_nxt     = w_rw_nxt & RW_MASK;
    w_sticky_nxt = (w_sticky_nxt | i_hw_event) & W1C_MASK;
  end

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      r_rw        <= RESET_VALUE & RW_MASK;
      r_sticky    <= '0;
      r_wr_strobe <= '0;
      r_irq       <= 1'b0;
      r_rd_data   <= '0;
      r_code      <= MEM_CODE_INVALID;
    end else begin
      r_rw        <= w_rw_nxt;
      r_sticky    <= w_sticky_nxt;
      r_wr_strobe <= w_wr_sel;
      r_irq       <= |w_sticky_nxt;
      r_rd_data   <= (w_code == MEM_CODE_READ) ? w_lane_rd : '0;
      r_code      <= w_code;
    end
  end

  assign o_regs          = r_rw;
  assign o_wr_strobe     = r_wr_strobe;
  assign o_irq           = r_irq;
  assign bus.res_rd_data = r_rd_data;
  assign bus.res_code    = r_code;

endmodule

// File: tb/tb_mmio_register_bank.sv
// Directed bench for mmio_register_bank: byte-level reference model compared every cycle,
// plus literal expectations at the key points of each scenario.
module tb_mmio_register_bank;
  import mmio_register_bank_pkg::*;

  localparam logic [31:0]  P_START = 32'h100;
  localparam logic [127:0] P_RW    = {32'h0, 32'h0, 32'h0000FFFF, 32'hFFFFFFFF};
  localparam logic [127:0] P_W1C   = {32'h0, 32'h000000FF, 32'h0, 32'h0};
  localparam logic [127:0] P_RST   = {96'h0, 32'h12345678};

  typedef struct packed {
    logic [3:0][31:0] rw;
    logic [3:0][31:0] st;
    mem_code_t        code;
    logic [31:0]      data;
    logic [3:0]       strobe;
  } mstate_t;

  logic         clk = 1'b0;
  logic         aresetn = 1'b0;
  logic [127:0] hw_status = '0;
  logic [127:0] hw_event = '0;
  logic [127:0] regs;
  logic [3:0]   wr_strobe;
  logic         irq;
  bit           chk_en = 1'b0;
  int           checks = 0;
  int           failures = 0;
  mstate_t      m;

  mmio_register_bank_if bus ();

  mmio_register_bank #(
    .WORD_COUNT (4),
    .ADDR_START (P_START),
    .RW_MASK    (P_RW),
    .W1C_MASK   (P_W1C),
    .RESET_VALUE(P_RST)
  ) dut (
    .clk        (clk),
    .aresetn    (aresetn),
    .bus        (bus),
    .i_hw_status(hw_status),
    .i_hw_event (hw_event),
    .o_regs     (regs),
    .o_wr_strobe(wr_strobe),
    .o_irq      (irq)
  );

  always #5 clk = ~clk;

  function automatic mstate_t model_reset();
    mstate_t r;
    r.rw     = P_RST & P_RW;
    r.st     = '0;
    r.code   = MEM_CODE_INVALID;
    r.data   = '0;
    r.strobe = '0;
    return r;
  endfunction

  // Byte-by-byte interpretation of one request against the current model state.
  function automatic mstate_t model_next(input mstate_t s, input logic [31:0] a, input mem_count_t c,
                                         input logic w, input logic [31:0] d,
                                         input logic [127:0] st_in, input logic [127:0] ev);
    mstate_t     n;
    int          nb, idx, lane, pos;
    logic [31:0] off, word;
    n = s;
    n.strobe = '0;
    n.data   = '0;
    nb   = (c == MEM_COUNT_BYTE) ? 1 : (c == MEM_COUNT_HALF) ? 2 : (c == MEM_COUNT_WORD) ? 4 : 0;
    off  = a - P_START;
    idx  = int'(off / 4) % 4;
    lane = int'(off % 4);
    if (nb == 0) n.code = MEM_CODE_INVALID;
    else if (lane % nb != 0) n.code = MEM_CODE_MISALIGNED;
    else if (a < P_START || (off / 4) >= 4) n.code = MEM_CODE_OUT_OF_RANGE;
    else if (w) begin
      n.code = MEM_CODE_WRITE;
      n.strobe[idx] = 1'b1;
      for (int b = 0; b < nb; b++)
        for (int j = 0; j < 8; j++) begin
          pos = (lane + b) * 8 + j;
          if (P_RW[idx*32 + pos]) n.rw[idx][pos] = d[b*8 + j];
          if (P_W1C[idx*32 + pos] && d[b*8 + j]) n.st[idx][pos] = 1'b0;
        end
    end else begin
      n.code = MEM_CODE_READ;
      for (int j = 0; j < 32; j++) begin
        pos = idx*32 + j;
        if (P_RW[pos])       word[j] = s.rw[idx][j];
        else if (P_W1C[pos]) word[j] = s.st[idx][j];
        else                 word[j] = st_in[pos];
      end
      for (int b = 0; b < nb; b++) n.data[b*8 +: 8] = word[(lane + b)*8 +: 8];
    end
    for (int k = 0; k < 128; k++)
      if (P_W1C[k] && ev[k]) n.st[k/32][k%32] = 1'b1;
    return n;
  endfunction

  always @(posedge clk or negedge aresetn) begin
    if (!aresetn) m <= model_reset();
    else m <= model_next(m, bus.req_addr, bus.req_count, bus.req_wr_en, bus.req_wr_data,
                         hw_status, hw_event);
  end

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("cmp_code",   bus.res_code, m.code);
      chk("cmp_data",   bus.res_rd_data, m.data);
      chk("cmp_regs",   regs, m.rw);
      chk("cmp_strobe", wr_strobe, m.strobe);
      chk("cmp_irq",    irq, |m.st);
    end
  end

  task automatic do_req(input logic [31:0] a, input mem_count_t c, input logic w, input logic [31:0] d);
    @(negedge clk);
    bus.req_addr    = a;
    bus.req_count   = c;
    bus.req_wr_en   = w;
    bus.req_wr_data = d;
  endtask

  task automatic idle();
    do_req(32'h0, MEM_COUNT_NONE, 1'b0, 32'h0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.req_addr = '0; bus.req_count = MEM_COUNT_NONE; bus.req_wr_en = 1'b0; bus.req_wr_data = '0;
    repeat (2) @(posedge clk);
    chk_en = 1'b1;
    @(negedge clk);
    chk("rst_regs", regs, {96'h0, 32'h12345678});
    chk("rst_code", bus.res_code, MEM_CODE_INVALID);
    aresetn = 1'b1;

    // 1: reset contents
    do_req(32'h100, MEM_COUNT_WORD, 1'b0, 32'h0); idle();
    chk("s1_data", bus.res_rd_data, 32'h12345678);
    chk("s1_code", bus.res_code, MEM_CODE_READ);
    chk("s1_irq", irq, 1'b0);

    // 2: byte write, strobe pulse, half and byte reads
    do_req(32'h102, MEM_COUNT_BYTE, 1'b1, 32'h000000AB); idle();
    chk("s2_code", bus.res_code, MEM_CODE_WRITE);
    chk("s2_strobe", wr_strobe, 4'b0001);
    chk("s2_word0", regs[31:0], 32'h12AB5678);
    idle();
    chk("s2_strobe_off", wr_strobe, 4'b0000);
    do_req(32'h102, MEM_COUNT_HALF, 1'b0, 32'h0); idle();
    chk("s2_half", bus.res_rd_data, 32'h000012AB);
    do_req(32'h103, MEM_COUNT_BYTE, 1'b0, 32'h0); idle();
    chk("s2_byte", bus.res_rd_data, 32'h00000012);

    // 3: mixed RW / read-only word
    hw_status[63:32] = 32'hCAFE1234;
    do_req(32'h104, MEM_COUNT_WORD, 1'b1, 32'hDEADBEEF);
    do_req(32'h104, MEM_COUNT_WORD, 1'b0, 32'h0); idle();
    chk("s3_read", bus.res_rd_data, 32'hCAFEBEEF);
    chk("s3_word1", regs[63:32], 32'h0000BEEF);

    // 4: sticky event, W1C clear, set-wins collision
    @(negedge clk); hw_event[67] = 1'b1;
    @(negedge clk); hw_event[67] = 1'b0;
    do_req(32'h108, MEM_COUNT_WORD, 1'b0, 32'h0); idle();
    chk("s4_sticky", bus.res_rd_data, 32'h00000008);
    chk("s4_irq_on", irq, 1'b1);
    do_req(32'h108, MEM_COUNT_WORD, 1'b1, 32'h00000008); idle();
    chk("s4_irq_off", irq, 1'b0);
    do_req(32'h108, MEM_COUNT_WORD, 1'b0, 32'h0); idle();
    chk("s4_cleared", bus.res_rd_data, 32'h0);
    @(negedge clk); hw_event[67] = 1'b1;
    @(negedge clk); hw_event[67] = 1'b0;
    do_req(32'h108, MEM_COUNT_WORD, 1'b1, 32'h00000008); hw_event[67] = 1'b1;
    do_req(32'h108, MEM_COUNT_WORD, 1'b0, 32'h0); hw_event[67] = 1'b0;
    idle();
    chk("s4_set_wins", bus.res_rd_data, 32'h00000008);
    chk("s4_irq_kept", irq, 1'b1);

    // 5: error responses
    do_req(32'h102, MEM_COUNT_WORD, 1'b0, 32'h0); idle();
    chk("s5_mis_word", bus.res_code, MEM_CODE_MISALIGNED);
    do_req(32'h101, MEM_COUNT_HALF, 1'b1, 32'hFFFF); idle();
    chk("s5_mis_half", bus.res_code, MEM_CODE_MISALIGNED);
    do_req(32'h110, MEM_COUNT_WORD, 1'b0, 32'h0); idle();
    chk("s5_oor_hi", bus.res_code, MEM_CODE_OUT_OF_RANGE);
    chk("s5_oor_data", bus.res_rd_data, 32'h0);
    do_req(32'h0FC, MEM_COUNT_WORD, 1'b0, 32'h0); idle();
    chk("s5_oor_lo", bus.res_code, MEM_CODE_OUT_OF_RANGE);
    do_req(32'h110, MEM_COUNT_WORD, 1'b1, 32'hFFFFFFFF); idle();
    chk("s5_oor_strobe", wr_strobe, 4'b0000);

    // 6: asynchronous reset during a write burst
    do_req(32'h100, MEM_COUNT_WORD, 1'b1, 32'h11111111);
    do_req(32'h104, MEM_COUNT_HALF, 1'b1, 32'h00002222);
    @(posedge clk); #2;
    aresetn = 1'b0;
    #1;
    chk("s6_regs", regs, {96'h0, 32'h12345678});
    chk("s6_strobe", wr_strobe, 4'b0000);
    chk("s6_code", bus.res_code, MEM_CODE_INVALID);
    chk("s6_data", bus.res_rd_data, 32'h0);
    chk("s6_irq", irq, 1'b0);
    idle();
    @(negedge clk); aresetn = 1'b1;
    do_req(32'h100, MEM_COUNT_WORD, 1'b0, 32'h0); idle();
    chk("s6_after", bus.res_rd_data, 32'h12345678);
    chk("s6_after_code", bus.res_code, MEM_CODE_READ);
    idle();
    @(negedge clk);
    chk_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mmio_register_bank.md
Name: mmio_register_bank

Overview:
Parametrised memory-mapped register bank for peripherals on the data-memory bus. Each bit of each word is one of three kinds:
- software read/write control
- hardware-set / write-1-to-clear sticky status
- read-only live hardware status

Supports byte, half and word reads and writes with a one-cycle registered response. Drives per-word write strobes and an interrupt line. Sits beside RAM in the memory peripheral decode; every new peripheral uses it as its CSR front-end.

Parameters:
WORD_COUNT, 4, number of 32-bit registers.
ADDR_START, 0, byte address of word 0; must be word-aligned.
RW_MASK, 0, WORD_COUNT*`WORD_W bits; 1 = bit is software read/write.
W1C_MASK, 0, WORD_COUNT*`WORD_W bits; 1 = sticky event bit; must not overlap RW_MASK.
RESET_VALUE, 0, WORD_COUNT*`WORD_W bits; reset contents of RW bits.

Ports:
clk  in  1  clock
aresetn  in  1  asynchronous active-low reset
i_req_addr  in  `ADDR_W  byte address
i_req_count  in  `MEM_COUNT_W  NONE/BYTE/HALF/WORD
i_req_wr_en  in  1  1 = write, 0 = read
i_req_wr_data  in  `WORD_W  store data, sub-word data in low lanes
i_hw_status  in  WORD_COUNT*`WORD_W  live values for read-only bits
i_hw_event  in  WORD_COUNT*`WORD_W  per-bit set pulses for W1C bits
o_regs  out  WORD_COUNT*`WORD_W  stored RW bits (non-RW bits read 0)
o_wr_strobe  out  WORD_COUNT  one-cycle pulse per word written
o_irq  out  1  OR of all sticky bits
o_res_rd_data  out  `WORD_W  read data
o_res_code  out  `MEM_CODE_W  response code

Behaviour:
- Clock and reset: one clock, clk. aresetn is asynchronous and active-low. It clears immediately, including mid-transaction:
  - RW storage = RESET_VALUE & RW_MASK
  - sticky bits = 0
  - o_wr_strobe = 0
  - o_res_rd_data = 0
  - o_res_code = `MEM_CODE_INVALID
- Decode:
  - off = i_req_addr - ADDR_START; idx = off[`ADDR_W-1:2]; lane = off[1:0].
  - In range iff i_req_addr >= ADDR_START and idx < WORD_COUNT.
- Word read value: (stored & RW) | (sticky & W1C) | (i_hw_status & ~(RW|W1C)). Values are sampled in the request cycle.
- Latency: every request is answered on the next clock edge. No stall, no back-pressure, one request per cycle.
- Checks, in priority order:
  1. count NONE -> code INVALID, data 0, no state change.
  2. Misaligned (HALF with lane[0]=1, or WORD with lane!=0) -> MISALIGNED, data 0, no state change.
  3. Out of range -> `MEM_CODE_OUT_OF_RANGE`, data 0, no state change.
  4. Otherwise a valid read or write.
- Read: code READ.
  - BYTE returns selected byte zero-extended into [7:0].
  - HALF returns selected half zero-extended into [15:0].
  - WORD returns the full word.
- Write: code `MEM_CODE_WRITE`, data 0.
  - Byte enables derived from count and lane. Source byte for lane k is i_req_wr_data byte (k mod width-in-bytes).
  - RW bits in enabled lanes take the new data.
  - W1C bits in enabled lanes with data 1 are cleared.
  - Read-only bits ignored.
  - o_wr_strobe[idx] pulses high for exactly the cycle after the write, even if no bit changed.
- Events: any cycle, i_hw_event bits at W1C positions set the sticky bit; other event bits are ignored. Event set and W1C clear of the same bit in one cycle -> bit stays 1 (set wins).
- o_irq: OR-reduction of the sticky register, driven directly from flops. It rises the cycle after the first event and falls the cycle after the last clear.

Decomposition:
- Add to mem_codes.vh: `MEM_CODE_WRITE and `MEM_CODE_OUT_OF_RANGE.
- Add to config.vh: byte-enable helper width `WORD_BYTES (= `WORD_W/8).
- Sub-module mem_lane_ctrl (combinational): inputs count and lane; outputs byte enables, misaligned flag, shifted write data and extracted read data. Shared later with the RAM wrapper.

Test Plan:
All scenarios use WORD_COUNT=4, ADDR_START=0x100, RW word0=0xFFFFFFFF, RW word1=0x0000FFFF, W1C word2=0x000000FF, RESET_VALUE word0=0x12345678.
1. Release reset; word read at 0x100 -> next cycle o_res_rd_data=0x12345678, code READ; o_irq=0.
2. Byte write 0xAB to 0x102 -> code WRITE; o_wr_strobe=0b0001 for one cycle; o_regs word0=0x12AB5678; half read at 0x102 -> 0x000012AB.
3. i_hw_status word1=0xCAFE1234; word write 0xDEADBEEF to 0x104 -> word read returns 0xCAFEBEEF.
4. i_hw_event word2 bit3 pulses one cycle:
   - Read 0x108 -> 0x00000008; o_irq=1.
   - Word write 0x8 -> read 0x0; o_irq=0 the following cycle.
   - Repeat with event and clear in the same cycle -> bit stays 1.
5. Word read at 0x102 -> MISALIGNED. Reads at 0x110 and 0x0FC -> OUT_OF_RANGE, data 0, no strobe, no state change.
6. Assert aresetn mid-burst of writes -> outputs and storage return to reset values immediately; the first request after release behaves as in scenario 1.
